param_fwd_alu_pipe: RTL and testbench
=====================================

Name: param_fwd_alu_pipe

Overview:
- Parametrised next-generation 2-stage pipelined ALU with an internal register file.
- Stage S1 latches operands fetched from the register file. Stage S2 holds the ALU result, which is both written back and presented on an output stream.
- Full forwarding (S2→S1 bypass plus RF write-through) removes all data-hazard stalls. The only stall source is output backpressure via a valid/ready handshake.
- Adds an immediate-load op, status flags and a retire counter.

Parameters:
- DATA_W, 32, operand/result width (≥8, power of 2).
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_op  in  4  opcode
- in_src1  in  ADDR_W  operand A register
- in_src2  in  ADDR_W  operand B register
- in_dest  in  ADDR_W  destination register
- in_imm  in  DATA_W  immediate, used by LDI only
- out_valid  out  1  result valid (S2 occupied)
- out_ready  in  1  consumer accepts result
- out_dest  out  ADDR_W  destination of result
- out_data  out  DATA_W  result
- out_flags  out  4  {N,Z,C,V} of result
- retire_cnt  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. All state clears on the next rising edge: s1_valid=0, s2_valid=0, all RF entries=0, out_dest=0, out_data=0, out_flags=0, retire_cnt=0. In-flight instructions are discarded with no RF write. in_ready=1 after reset.
- Stall: stall = s2_valid && !out_ready. in_ready = !stall. When stalled, S1 and S2 hold all contents.
- Issue: on accept, S1 captures op, src1, src2, dest, imm, and RF-read operands A/B.
  - RF read is combinational with write-through: if wb_en && wb_addr==src && src!=0, the read returns wb_data.
  - Register 0 always reads 0.
- Execute/forward (in S1):
  - opA_eff = (s1_src1!=0 && s2_valid && s2_dest==s1_src1) ? s2_data : s1_opA; opB_eff is formed the same way.
  - S2 captures the ALU result when !stall. s2_valid <= s1_valid, and s1_valid <= accept.
- Writeback: wb_en = s2_valid && out_ready && s2_dest!=0. RF[s2_dest] <= s2_data at that edge. retire_cnt increments on every out_valid && out_ready, including dest 0, and wraps modulo 2**CNT_W.
- Latency: instruction accepted at edge k → out_valid after edge k+1. Throughput is 1 per cycle, with no bubbles on dependency chains.
- Opcodes (all arithmetic modulo 2**DATA_W; shift amount = opB_eff[log2(DATA_W)-1:0]):

| Code | Mnemonic | Result |
|---|---|---|
| 0 | ADD | A+B |
| 1 | SUB | A−B |
| 2 | AND | A&B |
| 3 | OR | A\|B |
| 4 | XOR | A^B |
| 5 | SLL | A<<B |
| 6 | SRL | A>>B (logical) |
| 7 | SRA | A>>>B (arithmetic) |
| 8 | SLT | signed A<B → 1 else 0 |
| 9 | SLTU | unsigned A<B → 1 else 0 |
| 10 | MOVA | A |
| 11 | LDI | imm |
| 12–15 | reserved | 0, still written back |

- Flags: N=result[DATA_W-1]; Z=(result==0).
  - C for ADD = carry-out; for SUB = borrow (A<B unsigned); otherwise 0.
  - V = signed overflow for ADD/SUB; otherwise 0.
  - Flags are registered alongside s2_data.
- Simultaneous events: while S2 is writing back, S1 may read the same register (write-through) and S2 may forward to S1. Priority is S2 forward first, then RF write-through, then RF contents.
- Reset asserted while stalled: reset wins and the pipeline empties.

Test Plan:
- Dependency chain. Stimulus: LDI r1=5; ADD r2=r1,r1; ADD r3=r2,r1; SUB r4=r3,r2 issued back-to-back, out_ready=1. Required: out_data 5,10,15,5 on consecutive cycles; in_ready stays 1; retire_cnt=4.
- Distance-2 RF bypass. Stimulus: LDI r7=0xA5; LDI r8=1; XOR r9=r7,r7 (r7 produced two instructions earlier). Required: r9 result=0 with Z=1.
- Backpressure. Stimulus: out_ready=0 for 3 cycles with a result pending in S2. Required: in_ready=0 for those 3 cycles; out_data and out_dest stable; no RF write; S1 contents preserved; correct sequence resumes when out_ready returns to 1.
- Register 0 and flags.
  - LDI r0=7, then MOVA r1=r0 → r1 result=0.
  - LDI r2=3; LDI r3=5; SUB r4=r2,r3 → result 0xFFFFFFFE, N=1, C=1, V=0.
  - ADD 0x7FFFFFFF+1 → V=1.
- Shifts and compares. Stimulus: SRA of 0x80000000 by 4; SLT(−1,1); SLTU(−1,1). Required: 0xF8000000; 1; 0.
- Reset mid-flight. Stimulus: rst pulsed while S1 and S2 are both valid. Required: out_valid=0; retire_cnt=0; all registers read 0 afterwards.

Source files
------------

// File: rtl/param_fwd_alu_pipe.sv
// Two-stage pipelined ALU with an internal register file.
// S1 holds fetched operands, S2 holds the result and feeds writeback and the output stream.
module param_fwd_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_flags,
  output logic [CNT_W-1:0]  retire_cnt
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int SH_W     = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MOVA = 4'd10;
  localparam logic [3:0] OP_LDI  = 4'd11;

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic              s1_valid_q;
  logic [3:0]        s1_op_q;
  logic [ADDR_W-1:0] s1_src1_q, s1_src2_q, s1_dest_q;
  logic [DATA_W-1:0] s1_imm_q, s1_opa_q, s1_opb_q;

  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_dest_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [3:0]        s2_flags_q;
  logic [CNT_W-1:0]  retire_q;

  logic              stall, accept, wb_en, retire;
  logic [DATA_W-1:0] rd_a, rd_b, opa_eff, opb_eff, s2_data_d;
  logic [3:0]        s2_flags_d;
  logic [DATA_W:0]   add_w, sub_w;
  logic [SH_W-1:0]   shamt;
  logic              c_flag, v_flag;

  assign stall   = s2_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept  = in_valid && !stall;
  assign retire  = s2_valid_q && out_ready;
  assign wb_en   = retire && (s2_dest_q != '0);

  // RF read with write-through of the result retiring this cycle
  always_comb begin
    rd_a = rf_q[in_src1];
    rd_b = rf_q[in_src2];
    if (wb_en && s2_dest_q == in_src1) rd_a = s2_data_q;
    if (wb_en && s2_dest_q == in_src2) rd_b = s2_data_q;
    if (in_src1 == '0) rd_a = '0;
    if (in_src2 == '0) rd_b = '0;
  end

  assign opa_eff = (s1_src1_q != '0 && s2_valid_q && s2_dest_q == s1_src1_q) ? s2_data_q : s1_opa_q;
  assign opb_eff = (s1_src2_q != '0 && s2_valid_q && s2_dest_q == s1_src2_q) ? s2_data_q : s1_opb_q;

  assign add_w = {1'b0, opa_eff} + {1'b0, opb_eff};
  assign sub_w = {1'b0, opa_eff} - {1'b0, opb_eff};
  assign shamt = opb_eff[SH_W-1:0];

  always_comb begin
    s2_data_d = '0;
    c_flag    = 1'b0;
    v_flag    = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        s2_data_d = add_w[DATA_W-1:0];
        c_flag    = add_w[DATA_W];
        v_flag    = (opa_eff[DATA_W-1] == opb_eff[DATA_W-1]) &&
                    (add_w[DATA_W-1] != opa_eff[DATA_W-1]);
      end
      OP_SUB: begin
        s2_data_d = sub_w[DATA_W-1:0];
        c_flag    = sub_w[DATA_W];
        v_flag    = (opa_eff[DATA_W-1] != opb_eff[DATA_W-1]) &&
                    (sub_w[DATA_W-1] != opa_eff[DATA_W-1]);
      end
      OP_AND:  s2_data_d = opa_eff & opb_eff;
      OP_OR:   s2_data_d = opa_eff | opb_eff;
      OP_XOR:  s2_data_d = opa_eff ^ opb_eff;
      OP_SLL:  s2_data_d = opa_eff << shamt;
      OP_SRL:  s2_data_d = opa_eff >> shamt;
      OP_SRA:  s2_data_d = $signed(opa_eff) >>> shamt;
      OP_SLT:  s2_data_d = {{(DATA_W-1){1'b0}}, ($signed(opa_eff) < $signed(opb_eff))};
      OP_SLTU: s2_data_d = {{(DATA_W-1){1'b0}}, (opa_eff < opb_eff)};
      OP_MOVA: s2_data_d = opa_eff;
      OP_LDI:  s2_data_d = s1_imm_q;
      default: s2_data_d = '0;
    endcase
  end

  assign s2_flags_d = {s2_data_d[DATA_W-1], (s2_data_d == '0), c_flag, v_flag};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_src1_q  <= '0;
      s1_src2_q  <= '0;
      s1_dest_q  <= '0;
      s1_imm_q   <= '0;
      s1_opa_q   <= '0;
      s1_opb_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_dest_q  <= '0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
      retire_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_op_q   <= in_op;
          s1_src1_q <= in_src1;
          s1_src2_q <= in_src2;
          s1_dest_q <= in_dest;
          s1_imm_q  <= in_imm;
          s1_opa_q  <= rd_a;
          s1_opb_q  <= rd_b;
        end
        s2_valid_q <= s1_valid_q;
        s2_dest_q  <= s1_dest_q;
        s2_data_q  <= s2_data_d;
        s2_flags_q <= s2_flags_d;
      end
      if (wb_en) rf_q[s2_dest_q] <= s2_data_q;
      if (retire) retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_dest   = s2_dest_q;
  assign out_data   = s2_data_q;
  assign out_flags  = s2_flags_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_param_fwd_alu_pipe.sv
// Directed bench for param_fwd_alu_pipe: vector table plus stall and reset sequences.
module tb_param_fwd_alu_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 32;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9,
                         MOVA = 4'd10, LDI = 4'd11, RSV = 4'd12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [3:0]        in_op, out_flags;
  logic [ADDR_W-1:0] in_src1, in_src2, in_dest, out_dest;
  logic [DATA_W-1:0] in_imm, out_data;
  logic [CNT_W-1:0]  retire_cnt;

  param_fwd_alu_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_data(out_data), .out_flags(out_flags), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [ADDR_W-1:0] s1, s2, d;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] exp;
    logic [3:0]        fl;   // {N,Z,C,V}
  } vec_t;

  vec_t vq[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   base_ret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] op, input int s1, input int s2, input int d,
                     input logic [31:0] imm, input logic [31:0] exp, input logic [3:0] fl);
    vec_t v;
    v.op = op; v.s1 = ADDR_W'(s1); v.s2 = ADDR_W'(s2); v.d = ADDR_W'(d);
    v.imm = imm; v.exp = exp; v.fl = fl;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input int s1, input int s2, input int d,
                       input logic [31:0] imm);
    in_op = op; in_src1 = ADDR_W'(s1); in_src2 = ADDR_W'(s2); in_dest = ADDR_W'(d);
    in_imm = imm;
  endtask

  task automatic check_out(input string name, input logic [ADDR_W-1:0] d,
                           input logic [DATA_W-1:0] data, input logic [3:0] fl);
    check(name, {22'd0, out_valid, out_dest, out_flags, out_data}, {22'd0, 1'b1, d, fl, data});
  endtask

  // Issue the queued vectors back-to-back; each result is checked one cycle after issue.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op, int'(vq[i].s1), int'(vq[i].s2), int'(vq[i].d), vq[i].imm);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s_in_ready%0d", tag, i), {63'd0, in_ready}, 64'd1);
      if (i > 0) check_out($sformatf("%s_vec%0d", tag, i-1), vq[i-1].d, vq[i-1].exp, vq[i-1].fl);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out($sformatf("%s_vec%0d", tag, vq.size()-1), vq[vq.size()-1].d,
              vq[vq.size()-1].exp, vq[vq.size()-1].fl);
    @(posedge clk); #1;
    check($sformatf("%s_drained", tag), {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(ADD, 0, 0, 0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_retire", {32'd0, retire_cnt}, 64'd0);
    check("rst_out", {23'd0, out_dest, out_flags, out_data}, 64'd0);

    // dependency chain
    add(LDI, 0, 0, 1, 32'd5, 32'd5, 4'b0000);
    add(ADD, 1, 1, 2, 32'd0, 32'd10, 4'b0000);
    add(ADD, 2, 1, 3, 32'd0, 32'd15, 4'b0000);
    add(SUB, 3, 2, 4, 32'd0, 32'd5, 4'b0000);
    // distance-2 bypass
    add(LDI, 0, 0, 7, 32'hA5, 32'hA5, 4'b0000);
    add(LDI, 0, 0, 8, 32'd1, 32'd1, 4'b0000);
    add(XOR_, 7, 7, 9, 32'd0, 32'd0, 4'b0100);
    // register 0 and flags
    add(LDI, 0, 0, 0, 32'd7, 32'd7, 4'b0000);
    add(MOVA, 0, 0, 1, 32'd0, 32'd0, 4'b0100);
    add(LDI, 0, 0, 2, 32'd3, 32'd3, 4'b0000);
    add(LDI, 0, 0, 3, 32'd5, 32'd5, 4'b0000);
    add(SUB, 2, 3, 4, 32'd0, 32'hFFFF_FFFE, 4'b1010);
    add(LDI, 0, 0, 5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000);
    add(LDI, 0, 0, 6, 32'd1, 32'd1, 4'b0000);
    add(ADD, 5, 6, 10, 32'd0, 32'h8000_0000, 4'b1001);
    // shifts and compares
    add(LDI, 0, 0, 11, 32'h8000_0000, 32'h8000_0000, 4'b1000);
    add(LDI, 0, 0, 12, 32'd4, 32'd4, 4'b0000);
    add(SRA, 11, 12, 13, 32'd0, 32'hF800_0000, 4'b1000);
    add(LDI, 0, 0, 14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000);
    add(SLT, 14, 6, 15, 32'd0, 32'd1, 4'b0000);
    add(SLTU, 14, 6, 16, 32'd0, 32'd0, 4'b0100);
    add(SLL, 6, 12, 17, 32'd0, 32'd16, 4'b0000);
    add(SRL, 11, 12, 18, 32'd0, 32'h0800_0000, 4'b0000);
    add(AND_, 14, 12, 19, 32'd0, 32'd4, 4'b0000);
    add(OR_, 12, 6, 20, 32'd0, 32'd5, 4'b0000);
    add(ADD, 14, 6, 21, 32'd0, 32'd0, 4'b0110);
    add(SUB, 6, 6, 22, 32'd0, 32'd0, 4'b0100);
    add(LDI, 0, 0, 23, 32'd9, 32'd9, 4'b0000);
    add(RSV, 23, 23, 23, 32'd9, 32'd0, 4'b0100);
    add(MOVA, 23, 0, 24, 32'd0, 32'd0, 4'b0100);
    run_vecs("tbl");
    check("tbl_retire", {32'd0, retire_cnt}, 64'(vq.size()));
    base_ret = vq.size();

    // backpressure with a dependent instruction held in S1
    drive(LDI, 0, 0, 25, 32'h11); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(ADD, 25, 25, 26, 32'd0); out_ready = 1'b0;
    @(posedge clk); #1;
    check_out("bp_first", 5'd25, 32'h11, 4'b0000);
    drive(LDI, 0, 0, 27, 32'h33);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready%0d", k), {63'd0, in_ready}, 64'd0);
      check_out($sformatf("bp_hold%0d", k), 5'd25, 32'h11, 4'b0000);
      check($sformatf("bp_retire%0d", k), {32'd0, retire_cnt}, 64'(base_ret));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("bp_resume0", 5'd26, 32'h22, 4'b0000);
    @(posedge clk); #1;
    check_out("bp_resume1", 5'd27, 32'h33, 4'b0000);
    @(posedge clk); #1;
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    check("bp_retire", {32'd0, retire_cnt}, 64'(base_ret + 3));

    // reset with S1 and S2 both occupied and the output stalled
    drive(LDI, 0, 0, 1, 32'h55); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(LDI, 0, 0, 2, 32'h66);
    @(posedge clk); #1;
    check_out("rmf_pre", 5'd1, 32'h55, 4'b0000);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    check("rmf_out_valid", {63'd0, out_valid}, 64'd0);
    check("rmf_retire", {32'd0, retire_cnt}, 64'd0);
    check("rmf_in_ready", {63'd0, in_ready}, 64'd1);
    check("rmf_out", {23'd0, out_dest, out_flags, out_data}, 64'd0);
    @(posedge clk); #1;
    check("rmf_no_ghost", {63'd0, out_valid}, 64'd0);

    vq.delete();
    add(MOVA, 1, 0, 1, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 2, 0, 3, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 25, 0, 4, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 26, 0, 5, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 27, 0, 6, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 14, 0, 7, 32'd0, 32'd0, 4'b0100);
    add(MOVA, 11, 0, 8, 32'd0, 32'd0, 4'b0100);
    run_vecs("post");
    check("post_retire", {32'd0, retire_cnt}, 64'd7);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
